// File: rtl/load_store_unit.sv
// Memory-access stage: byte/half/word loads and stores over a single-outstanding req/ack bus.
// Optional ack timeout is enabled by defining LSU_TIMEOUT_EN.
module load_store_unit #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ex_valid,
  output logic                  ex_ready,
  input  logic [DATA_WIDTH-1:0] ALU_o,
  input  logic [DATA_WIDTH-1:0] WD,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [2:0]            Funct3,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_be,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  wb_valid,
  output logic [DATA_WIDTH-1:0] Result,
  output logic                  err
);

  typedef enum logic {IDLE, REQ} state_t;

  state_t state, state_nx;

  logic [DATA_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [3:0]            be_q;
  logic [2:0]            f3_q;
  logic                  we_q;

  logic                  hs, is_mem, illegal, misal, go, done, tmo;
  logic [3:0]            st_be;
  logic [DATA_WIDTH-1:0] st_wdata;
  logic [DATA_WIDTH-1:0] ld_data;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;

  assign ex_ready  = (state == IDLE);
  assign mem_req   = (state == REQ);
  assign mem_we    = we_q;
  assign mem_addr  = {addr_q[DATA_WIDTH-1:2], 2'b00};
  assign mem_wdata = wdata_q;
  assign mem_be    = be_q;

  assign hs      = ex_valid & ex_ready;
  assign is_mem  = MemRead | MemWrite;
  assign illegal = (MemRead & MemWrite)
                 | (MemRead & ((Funct3 == 3'b011) | (Funct3[2:1] == 2'b11)))
                 | (MemWrite & Funct3[2]);
  assign misal   = ((Funct3[1:0] == 2'b01) & ALU_o[0])
                 | ((Funct3[1:0] == 2'b10) & (|ALU_o[1:0]));
  assign go      = hs & is_mem & ~illegal & ~misal;
  assign done    = (state == REQ) & mem_ack;

`ifdef LSU_TIMEOUT_EN
  localparam int CLOG = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW   = (CLOG > 8) ? CLOG : 8;

  logic [CW-1:0] cnt;

  // cnt counts REQ cycles already spent without ack
  assign tmo = (state == REQ) & ~mem_ack
             & (cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (go) begin
      cnt <= '0;
    end else if ((state == REQ) && !mem_ack) begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  logic unused_cfg;
  assign tmo        = 1'b0;
  assign unused_cfg = (TIMEOUT_CYCLES == 0);
`endif

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = WD;
    unique case (1'b1)
      Funct3[1:0] == 2'b00: begin
        st_be    = 4'b0001 << ALU_o[1:0];
        st_wdata = {4{WD[7:0]}};
      end
      Funct3[1:0] == 2'b01: begin
        st_be    = ALU_o[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{WD[15:0]}};
      end
      default: ;
    endcase
  end

  assign ld_byte = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
  assign ld_half = mem_rdata[{addr_q[1], 4'b0000} +: 16];

  always_comb begin
    ld_data = mem_rdata;
    unique case (1'b1)
      f3_q == 3'b000: ld_data = {{24{ld_byte[7]}}, ld_byte};
      f3_q == 3'b001: ld_data = {{16{ld_half[15]}}, ld_half};
      f3_q == 3'b100: ld_data = {24'd0, ld_byte};
      f3_q == 3'b101: ld_data = {16'd0, ld_half};
      default: ;
    endcase
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (go) state_nx = REQ;
      REQ:  if (done || tmo) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      f3_q     <= '0;
      we_q     <= 1'b0;
      wb_valid <= 1'b0;
      err      <= 1'b0;
      Result   <= '0;
    end else begin
      state    <= state_nx;
      wb_valid <= 1'b0;
      err      <= 1'b0;
      if (hs && !go) begin
        wb_valid <= 1'b1;
        err      <= is_mem;
        Result   <= ALU_o;
      end
      if (go) begin
        addr_q  <= ALU_o;
        f3_q    <= Funct3;
        we_q    <= MemWrite;
        be_q    <= MemWrite ? st_be : 4'b1111;
        wdata_q <= MemWrite ? st_wdata : '0;
      end
      if (done) begin
        wb_valid <= 1'b1;
        Result   <= we_q ? addr_q : ld_data;
      end else if (tmo) begin
        wb_valid <= 1'b1;
        err      <= 1'b1;
        Result   <= addr_q;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized self-checking bench for load_store_unit against a behavioural model.
// Covers reset, pass-through, loads, stores, errors, back-to-back and timeout.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ALU_o, WD;
  logic        MemRead, MemWrite;
  logic [2:0]  Funct3;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        wb_valid;
  logic [31:0] Result;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  load_store_unit #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ALU_o(ALU_o), .WD(WD),
    .MemRead(MemRead), .MemWrite(MemWrite), .Funct3(Funct3),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .Result(Result), .err(err)
  );

  // 0 = pass-through, 1 = error, 2 = memory access
  function automatic int classify(bit mr, bit mw, bit [2:0] f3, bit [31:0] a);
    int sz;
    if (!mr && !mw) return 0;
    if (mr && mw) return 1;
    if (mr && (f3 == 3 || f3 == 6 || f3 == 7)) return 1;
    if (mw && f3 >= 4) return 1;
    sz = f3 % 4;
    if (sz == 1 && a % 2 != 0) return 1;
    if (sz == 2 && a % 4 != 0) return 1;
    return 2;
  endfunction

  function automatic bit [31:0] model_load(bit [2:0] f3, bit [31:0] a,
                                           bit [31:0] rd);
    bit [31:0] b, h;
    b = (rd >> (8 * (a % 4))) % 256;
    h = (rd >> (16 * ((a / 2) % 2))) % 65536;
    case (f3)
      3'd0: return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd1: return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd4: return b;
      3'd5: return h;
      default: return rd;
    endcase
  endfunction

  function automatic bit [3:0] model_be(bit mw, bit [2:0] f3, bit [31:0] a);
    if (!mw) return 4'd15;
    if (f3 % 4 == 0) return 4'(1 << (a % 4));
    if (f3 % 4 == 1) return (a % 4 >= 2) ? 4'd12 : 4'd3;
    return 4'd15;
  endfunction

  function automatic bit [31:0] model_wdata(bit [2:0] f3, bit [31:0] d);
    if (f3 % 4 == 0) return (d % 256) * 32'h0101_0101;
    if (f3 % 4 == 1) return (d % 65536) * 32'h0001_0001;
    return d;
  endfunction

  // Issues one op from a negedge and runs it to write-back; returns at the
  // negedge of the write-back cycle so the next op can issue back-to-back.
  task automatic do_op(string tag, bit mr, bit mw, bit [2:0] f3,
                       bit [31:0] a, bit [31:0] wd, bit [31:0] rd, int waits);
    int k;
    bit [31:0] exp_res;
    k = classify(mr, mw, f3, a);
    n_checks++;
    if (ex_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s issue ex_ready got %0b want 1", tag, ex_ready);
    end
    ex_valid = 1'b1; MemRead = mr; MemWrite = mw; Funct3 = f3;
    ALU_o = a; WD = wd;
    @(negedge clk);
    ex_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    ALU_o = $urandom; WD = $urandom;
    if (k != 2) begin
      n_checks++;
      if (wb_valid !== 1'b1 || err !== (k == 1) || mem_req !== 1'b0) begin
        n_fail++;
        $display("FAIL %s wb/err/req got %0b%0b%0b want 1%0b0",
                 tag, wb_valid, err, mem_req, k == 1);
      end
      if (k == 0) begin
        n_checks++;
        if (Result !== a) begin
          n_fail++;
          $display("FAIL %s pass Result got %h want %h", tag, Result, a);
        end
      end
      return;
    end
    n_checks++;
    if (mem_req !== 1'b1 || ex_ready !== 1'b0 || mem_we !== mw ||
        mem_addr !== (a - a % 4) || mem_be !== model_be(mw, f3, a)) begin
      n_fail++;
      $display("FAIL %s bus req%0b rdy%0b we%0b addr %h be %b want 10%0b %h %b",
               tag, mem_req, ex_ready, mem_we, mem_addr, mem_be, mw,
               a - a % 4, model_be(mw, f3, a));
    end
    if (mw) begin
      n_checks++;
      if (mem_wdata !== model_wdata(f3, wd)) begin
        n_fail++;
        $display("FAIL %s wdata got %h want %h", tag, mem_wdata,
                 model_wdata(f3, wd));
      end
    end
    for (int w = 0; w < waits; w++) begin
      @(negedge clk);
      n_checks++;
      if (mem_req !== 1'b1 || wb_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL %s wait%0d req got %0b wb %0b want 1 0",
                 tag, w, mem_req, wb_valid);
      end
    end
    mem_ack = 1'b1; mem_rdata = rd;
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = $urandom;
    exp_res = mw ? a : model_load(f3, a, rd);
    n_checks++;
    if (wb_valid !== 1'b1 || err !== 1'b0 || mem_req !== 1'b0 ||
        ex_ready !== 1'b1 || Result !== exp_res) begin
      n_fail++;
      $display("FAIL %s wb v%0b e%0b req%0b rdy%0b Result %h want 1001 %h",
               tag, wb_valid, err, mem_req, ex_ready, Result, exp_res);
    end
  endtask

  task automatic idle_check(string tag);
    @(negedge clk);
    n_checks++;
    if (wb_valid !== 1'b0 || mem_req !== 1'b0 || ex_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s idle wb %0b req %0b rdy %0b want 0 0 1",
               tag, wb_valid, mem_req, ex_ready);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n_checks++;
    if (ex_ready !== 1'b1 || mem_req !== 1'b0 || mem_we !== 1'b0 ||
        wb_valid !== 1'b0 || err !== 1'b0 || mem_addr !== 32'd0 ||
        mem_wdata !== 32'd0 || mem_be !== 4'd0 || Result !== 32'd0) begin
      n_fail++;
      $display("FAIL reset rdy%0b req%0b we%0b wb%0b err%0b %h %h %b %h",
               ex_ready, mem_req, mem_we, wb_valid, err, mem_addr,
               mem_wdata, mem_be, Result);
    end
  endtask

  task automatic test_passthrough;
    do_op("pass0", 0, 0, 3'd0, 32'h10, 32'h0, 32'h0, 0);
    do_op("pass1", 0, 0, 3'd0, 32'h20, 32'h0, 32'h0, 0);
    do_op("pass2", 0, 0, 3'd0, 32'h30, 32'h0, 32'h0, 0);
    idle_check("pass_end");
  endtask

  task automatic test_loads;
    do_op("lb",  1, 0, 3'd0, 32'h103, 32'h0, 32'h80FF_1234, 2);
    do_op("lbu", 1, 0, 3'd4, 32'h103, 32'h0, 32'h80FF_1234, 2);
    do_op("lh",  1, 0, 3'd1, 32'h102, 32'h0, 32'h80FF_1234, 1);
    do_op("lhu", 1, 0, 3'd5, 32'h100, 32'h0, 32'h80FF_9234, 0);
    do_op("lw",  1, 0, 3'd2, 32'h104, 32'h0, 32'hCAFE_F00D, 0);
    idle_check("load_end");
  endtask

  task automatic test_stores;
    do_op("sh", 0, 1, 3'd1, 32'h202, 32'hDEAD_BEEF, 32'h0, 1);
    do_op("sb", 0, 1, 3'd0, 32'h201, 32'h1234_56A5, 32'h0, 0);
    do_op("sw", 0, 1, 3'd2, 32'h208, 32'h0BAD_CAFE, 32'h0, 3);
    idle_check("store_end");
  endtask

  task automatic test_errors;
    do_op("lw_mis", 1, 0, 3'd2, 32'h301, 32'h0, 32'h0, 0);
    do_op("lh_mis", 1, 0, 3'd1, 32'h303, 32'h0, 32'h0, 0);
    do_op("rw_ill", 1, 1, 3'd2, 32'h300, 32'h0, 32'h0, 0);
    do_op("ld_011", 1, 0, 3'd3, 32'h300, 32'h0, 32'h0, 0);
    do_op("st_100", 0, 1, 3'd4, 32'h300, 32'h0, 32'h0, 0);
    idle_check("err_end");
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 200; i++) begin
      bit [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a = a - a % 4 + 4 * $urandom_range(0, 1);
      do_op($sformatf("rnd%0d", i), 1'($urandom), 1'($urandom),
            3'($urandom), a, $urandom, $urandom, $urandom_range(0, 3));
    end
    idle_check("rnd_end");
  endtask

  task automatic test_reset_mid;
    ex_valid = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; Funct3 = 3'd2;
    ALU_o = 32'h400;
    @(negedge clk);
    ex_valid = 1'b0; MemRead = 1'b0;
    n_checks++;
    if (mem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid req got %0b want 1", mem_req);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_checks++;
    if (mem_req !== 1'b0 || wb_valid !== 1'b0 || ex_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid after req %0b wb %0b rdy %0b want 0 0 1",
               mem_req, wb_valid, ex_ready);
    end
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    n_checks++;
    if (wb_valid !== 1'b0 || mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL stray_ack wb %0b req %0b want 0 0", wb_valid, mem_req);
    end
  endtask

  task automatic test_timeout;
    int hi;
    ex_valid = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; Funct3 = 3'd2;
    ALU_o = 32'h500;
    @(negedge clk);
    ex_valid = 1'b0; MemRead = 1'b0;
    hi = 0;
    while (mem_req === 1'b1 && hi < 150) begin
      hi++;
      @(negedge clk);
    end
`ifdef LSU_TIMEOUT_EN
    n_checks++;
    if (hi != 4 || wb_valid !== 1'b1 || err !== 1'b1 || Result !== 32'h500) begin
      n_fail++;
      $display("FAIL timeout req cycles %0d wb %0b err %0b Result %h want 4 1 1 500",
               hi, wb_valid, err, Result);
    end
`else
    n_checks++;
    if (hi < 100 || wb_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL no_timeout req cycles %0d wb %0b want >=100 0", hi, wb_valid);
    end
    mem_ack = 1'b1; mem_rdata = 32'h1357_9BDF;
    @(negedge clk);
    mem_ack = 1'b0;
    n_checks++;
    if (wb_valid !== 1'b1 || err !== 1'b0 || Result !== 32'h1357_9BDF) begin
      n_fail++;
      $display("FAIL late_ack wb %0b err %0b Result %h want 1 0 13579bdf",
               wb_valid, err, Result);
    end
`endif
    idle_check("tmo_end");
  endtask

  initial begin
    rst_n = 1'b0; ex_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    Funct3 = 3'd0; ALU_o = 32'd0; WD = 32'd0;
    mem_ack = 1'b0; mem_rdata = 32'd0;
    @(negedge clk);
    test_reset;
    test_passthrough;
    test_loads;
    test_stores;
    test_errors;
    test_back_to_back;
    test_reset_mid;
    test_timeout;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
